adc_sample_fifo_ctrl: RTL and testbench
=======================================

// Module: adc_sample_fifo_ctrl
// PURPOSE
//  Register-side ADC run controller and sample buffer. It decodes CPU accesses from gpio_adr_decoder_reg
//  (0x0300 control/status, 0x0304 data) and sequences N conversions through the LTC2308 SPI engine.
//  Results are buffered in a FIFO that the CPU drains via 0x0304.
//  Sits between the address decoder (upstream) and the SPI conversion engine (downstream).
// PARAMETERS
//  FifoDepth   1024  sample entries; power of 2, 16..4096
//  DataWidth   12    ADC result width
//  ChWidth     3     channel select width (8 channels)
//  BusWidth    32    CPU data width
// PORTS
//  reg_clk      in   1         single clock, all logic posedge
//  reset_in     in   1         synchronous, active-high
//  write        in   1         1-cycle CPU write strobe (address already qualified as ADC)
//  read         in   1         1-cycle CPU read strobe (address already qualified as ADC)
//  addr         in   1         0 = 0x0300 ctrl/status, 1 = 0x0304 data
//  writedatain  in   BusWidth  CPU write data
//  readdataout  out  BusWidth  registered read data
//  conv_start   out  1         1-cycle pulse to SPI engine
//  conv_ch      out  ChWidth   channel for the pending conversion, stable from conv_start to conv_done
//  conv_done    in   1         1-cycle pulse from SPI engine, result valid
//  conv_data    in   DataWidth conversion result, valid with conv_done
// BEHAVIOUR
//  Reset:
//   - readdataout = 0, conv_start = 0, conv_ch = 0.
//   - FIFO empty; state IDLE; sticky flags cleared; count = 0.
//  Ctrl write (addr=0), fields wd[0] start, wd[3:1] ch, wd[15:4] count:
//   - Start=1 while IDLE or DONE: flush FIFO, clear sticky flags, latch ch and count, go to ARM.
//     Count is clamped to FifoDepth.
//   - Start=1 while ARM, WAIT or STORE: ignored.
//   - Start=0 in any state: abort, flush FIFO, go to IDLE.
//  FSM:
//   - IDLE: wait for a start.
//   - ARM: pulse conv_start for 1 cycle, go to WAIT.
//   - WAIT: on conv_done go to STORE; stay indefinitely otherwise (no timeout).
//   - STORE: push conv_data, decrement remaining; remaining = 0 ? DONE : ARM.
//   - DONE: hold until the next ctrl write.
//   - Count = 0: ARM is skipped, IDLE goes straight to DONE.
//   - conv_done arriving outside WAIT is discarded.
//  Status read (addr=0), readdataout one cycle after read:
//   - [0] done, [1] busy (ARM/WAIT/STORE), [2] overflow sticky, [3] underflow sticky.
//   - [16+:13] FIFO level (0..FifoDepth); all other bits 0.
//  Data read (addr=1), readdataout one cycle after read:
//   - Not empty: {zero-pad, head sample}; pop in the same cycle.
//   - Empty: returns 0 and sets underflow; no pop.
//  Boundaries:
//   - Push while full: sample dropped, overflow set, remaining still decremented.
//   - Push and pop in the same cycle: both happen, level unchanged. Full + simultaneous pop: push accepted.
//   - Read and write in the same cycle: write takes effect; read returns pre-write status/data.
//   - FIFO pointers wrap modulo FifoDepth; level counter is 1 bit wider than the pointers.
//   - Reset mid-run: immediate IDLE, conv_start forced 0; a late conv_done is discarded.
// CONFIGURATION
//  ADC_SCAN_EN defined:
//   - conv_ch auto-increments per conversion, modulo 2^ChWidth, starting at the latched ch.
//   - Data word is {zero-pad, ch tag at [14:12], sample[11:0]}; FIFO width becomes DataWidth+ChWidth.
//  ADC_SCAN_EN undefined:
//   - conv_ch fixed for the whole run; data bits [31:12] = 0.
// STRUCTURE
//  adc_pkg:
//   - Register offsets ADC_CTRL_OFS = 'h0300, ADC_DATA_OFS = 'h0304.
//   - Ctrl/status bit-position localparams.
//   - typedef enum adc_state_t {IDLE, ARM, WAIT, STORE, DONE}.
//  Sub-module sync_fifo #(Width, Depth):
//   - Single-clock, inferred RAM, registered read, push/pop/flush, full/empty/level.
//  This module holds the FSM, counters, sticky flags and the read mux.
// TESTING
//  T1: ctrl write 'h0000_0031 (count 3, ch 0, start); model returns 'h123, 'h456, 'h789
//      -> 3 conv_start pulses, status done=1 level=3; three data reads give 'h123, 'h456, 'h789; level=0.
//  T2: data read with FIFO empty -> readdataout 0, status underflow=1; the next start clears it.
//  T3: FifoDepth=16, count clamps to 16, drain nothing -> level 16, overflow=0;
//      pop during the 16th push keeps level 15->15.
//  T4: start count 8; at conversion 4 write 'h0 -> state IDLE, level 0, no further conv_start;
//      a late conv_done is ignored.
//  T5: reset_in asserted during WAIT -> all outputs 0 next cycle; status reads 0 after reset.
//  T6 (ADC_SCAN_EN): ch=6, count 4 -> conv_ch 6,7,0,1; data words carry tags 6,7,0,1 in [14:12].

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared register offsets, ctrl/status bit positions and FSM state type
// for adc_sample_fifo_ctrl.
package adc_pkg;

   localparam logic [15:0] ADC_CTRL_OFS = 16'h0300;
   localparam logic [15:0] ADC_DATA_OFS = 16'h0304;

   localparam int CTRL_START = 0;
   localparam int CTRL_CH    = 1;
   localparam int CTRL_CNT   = 4;
   localparam int CTRL_CNT_W = 12;

   localparam int ST_DONE  = 0;
   localparam int ST_BUSY  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_UDF   = 3;
   localparam int ST_LVL   = 16;
   localparam int ST_LVL_W = 13;

   typedef enum logic [2:0] {IDLE, ARM, WAIT, STORE, DONE} adc_state_t;

   function automatic logic is_busy(input adc_state_t s);
      return s inside {ARM, WAIT, STORE};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, inferred RAM with registered read data,
// push/pop/flush and full/empty/level; a push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int Width = 12,
   parameter int Depth = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [Width-1:0]           wdata_i,
   output logic [Width-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth):0]     level_o
);

   localparam int AW = $clog2(Depth);
   localparam int LW = AW + 1;

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_q, rd_q;
   logic [LW-1:0]    level_q;
   logic [Width-1:0] rdata_q;
   logic             do_push, do_pop;

   assign full_o  = level_q == LW'(Depth);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
   assign rdata_o = rdata_q;
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         rdata_q <= '0;
      end else begin
         if (do_pop) rdata_q <= mem[rd_q];
         if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
         end else begin
            wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
         end
      end
   end

endmodule

// File: rtl/adc_sample_fifo_ctrl.sv
// adc_sample_fifo_ctrl: CPU-facing ADC run sequencer and sample buffer in front of the SPI engine.
// Define ADC_SCAN_EN to auto-increment the channel per conversion and tag each sample with it.
module adc_sample_fifo_ctrl
   import adc_pkg::*;
#(
   parameter int FifoDepth = 1024,
   parameter int DataWidth = 12,
   parameter int ChWidth   = 3,
   parameter int BusWidth  = 32
) (
   input  logic                 reg_clk,
   input  logic                 reset_in,
   input  logic                 write,
   input  logic                 read,
   input  logic                 addr,
   input  logic [BusWidth-1:0]  writedatain,
   output logic [BusWidth-1:0]  readdataout,
   output logic                 conv_start,
   output logic [ChWidth-1:0]   conv_ch,
   input  logic                 conv_done,
   input  logic [DataWidth-1:0] conv_data
);

   localparam int LW = $clog2(FifoDepth) + 1;
`ifdef ADC_SCAN_EN
   localparam int FW = DataWidth + ChWidth;
`else
   localparam int FW = DataWidth;
`endif

   adc_state_t           state_q, state_d;
   logic [LW-1:0]        rem_q, rem_d, clamp, fifo_level;
   logic [ChWidth-1:0]   ch_q, ch_d;
   logic [DataWidth-1:0] sample_q, sample_d;
   logic                 ovf_q, ovf_d, udf_q, udf_d;
   logic [BusWidth-1:0]  rd_q, rd_d, status;
   logic                 sel_q, sel_d;
   logic                 push, pop, flush, fifo_full, fifo_empty;
   logic                 ctrl_wr, data_rd;
   logic [FW-1:0]        push_data, pop_data;
   logic [CTRL_CNT_W:0]  cnt_x;
   logic                 unused_ok;

   assign unused_ok   = &{1'b0, writedatain[BusWidth-1:CTRL_CNT+CTRL_CNT_W], ADC_CTRL_OFS, ADC_DATA_OFS};
   assign ctrl_wr     = write & ~addr;
   assign data_rd     = read & addr;
   assign pop         = data_rd & ~fifo_empty;
   assign cnt_x       = {1'b0, writedatain[CTRL_CNT +: CTRL_CNT_W]};
   assign clamp       = (cnt_x > (CTRL_CNT_W+1)'(FifoDepth)) ? LW'(FifoDepth) : LW'(cnt_x);
   assign conv_start  = state_q == ARM;
   assign conv_ch     = ch_q;
   assign readdataout = sel_q ? BusWidth'(pop_data) : rd_q;
`ifdef ADC_SCAN_EN
   assign push_data   = {ch_q, sample_q};
`else
   assign push_data   = sample_q;
`endif

   always_comb begin
      status                     = '0;
      status[ST_DONE]            = state_q == DONE;
      status[ST_BUSY]            = is_busy(state_q);
      status[ST_OVF]             = ovf_q;
      status[ST_UDF]             = udf_q;
      status[ST_LVL +: ST_LVL_W] = ST_LVL_W'(fifo_level);
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      ch_d     = ch_q;
      sample_d = sample_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q | (data_rd & fifo_empty);
      rd_d     = read ? (addr ? '0 : status) : rd_q;
      sel_d    = read ? pop : sel_q;
      push     = 1'b0;
      flush    = 1'b0;
      case (state_q)
         ARM:   state_d = WAIT;
         WAIT: begin
            state_d  = conv_done ? STORE : WAIT;
            sample_d = conv_done ? conv_data : sample_q;
         end
         STORE: begin
            push    = 1'b1;
            ovf_d   = ovf_q | (fifo_full & ~pop);
            rem_d   = rem_q - LW'(1);
            state_d = (rem_q == LW'(1)) ? DONE : ARM;
`ifdef ADC_SCAN_EN
            ch_d    = ch_q + ChWidth'(1);
`endif
         end
         default: ;
      endcase
      // An abort is honoured in every state; a new start only from IDLE/DONE.
      if (ctrl_wr && !writedatain[CTRL_START]) begin
         state_d = IDLE;
         flush   = 1'b1;
      end else if (ctrl_wr && (state_q == IDLE || state_q == DONE)) begin
         flush   = 1'b1;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
         ch_d    = writedatain[CTRL_CH +: ChWidth];
         rem_d   = clamp;
         state_d = (clamp == '0) ? DONE : ARM;
      end
   end

   always_ff @(posedge reg_clk) begin
      if (reset_in) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         ch_q     <= '0;
         sample_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rd_q     <= '0;
         sel_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         ch_q     <= ch_d;
         sample_q <= sample_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rd_q     <= rd_d;
         sel_q    <= sel_d;
      end
   end

   sync_fifo #(.Width(FW), .Depth(FifoDepth)) u_fifo (
      .clk_i   (reg_clk),
      .rst_i   (reset_in),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (push_data),
      .rdata_o (pop_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

endmodule

// File: tb/tb_adc_sample_fifo_ctrl.sv
// tb_adc_sample_fifo_ctrl: directed bench for adc_sample_fifo_ctrl with a 16-entry FIFO;
// honours ADC_SCAN_EN for channel/tag expectations.
module tb_adc_sample_fifo_ctrl;

   logic        reg_clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        write = 1'b0, read = 1'b0, addr = 1'b0;
   logic [31:0] writedatain = '0;
   logic [31:0] readdataout;
   logic        conv_start;
   logic [2:0]  conv_ch;
   logic        conv_done = 1'b0;
   logic [11:0] conv_data = '0;
   int          passed = 0, fails = 0, total = 0, starts = 0, s0;
   logic [31:0] v;

   adc_sample_fifo_ctrl #(.FifoDepth(16)) dut (
      .reg_clk     (reg_clk),
      .reset_in    (reset_in),
      .write       (write),
      .read        (read),
      .addr        (addr),
      .writedatain (writedatain),
      .readdataout (readdataout),
      .conv_start  (conv_start),
      .conv_ch     (conv_ch),
      .conv_done   (conv_done),
      .conv_data   (conv_data)
   );

   always #5 reg_clk = ~reg_clk;

   always @(negedge reg_clk) if (conv_start === 1'b1) starts++;

   function automatic logic [2:0] ch_at(input int s, input int i);
`ifdef ADC_SCAN_EN
      return 3'(s + i);
`else
      return 3'(s);
`endif
   endfunction

   function automatic logic [31:0] word(input logic [11:0] d, input logic [2:0] tag);
`ifdef ADC_SCAN_EN
      return {17'b0, tag, d};
`else
      return {20'b0, d};
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge reg_clk);
      #1;
   endtask

   task automatic ctrl_wr(input logic [31:0] d);
      write = 1'b1; addr = 1'b0; writedatain = d;
      tick();
      write = 1'b0;
   endtask

   task automatic rd(input logic a, output logic [31:0] q);
      read = 1'b1; addr = a;
      tick();
      read = 1'b0; addr = 1'b0;
      q = readdataout;
   endtask

   task automatic wait_start(input logic [2:0] exp_ch);
      int n = 0;
      while (conv_start !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("conv_start_seen", {31'b0, conv_start}, 32'h1);
      check("conv_ch", {29'b0, conv_ch}, {29'b0, exp_ch});
   endtask

   task automatic conv(input logic [11:0] d, input logic [2:0] exp_ch, input bit pop_store,
                       input logic [31:0] exp_pop);
      wait_start(exp_ch);
      tick();
      conv_done = 1'b1; conv_data = d;
      tick();
      conv_done = 1'b0; conv_data = '0;
      if (pop_store) begin
         rd(1'b1, v);
         check("pop_in_store", v, exp_pop);
      end
   endtask

   initial begin
      repeat (3) tick();
      check("rst_rdata", readdataout, 32'h0);
      check("rst_start", {31'b0, conv_start}, 32'h0);
      check("rst_ch", {29'b0, conv_ch}, 32'h0);
      reset_in = 1'b0;
      rd(1'b0, v);
      check("rst_status", v, 32'h0);

      // T1: three conversions then drain
      s0 = starts;
      ctrl_wr(32'h31);
      conv(12'h123, ch_at(0, 0), 1'b0, 32'h0);
      conv(12'h456, ch_at(0, 1), 1'b0, 32'h0);
      conv(12'h789, ch_at(0, 2), 1'b0, 32'h0);
      tick();
      check("t1_starts", starts - s0, 32'd3);
      rd(1'b0, v); check("t1_status", v, 32'h0003_0001);
      rd(1'b1, v); check("t1_d0", v, word(12'h123, ch_at(0, 0)));
      rd(1'b1, v); check("t1_d1", v, word(12'h456, ch_at(0, 1)));
      rd(1'b1, v); check("t1_d2", v, word(12'h789, ch_at(0, 2)));
      rd(1'b0, v); check("t1_empty_status", v, 32'h0000_0001);

      // T2: underflow
      rd(1'b1, v); check("t2_udf_data", v, 32'h0);
      rd(1'b0, v); check("t2_udf_status", v, 32'h0000_0009);

      // T3a: count 20 clamps to 16, FIFO fills without overflow
      s0 = starts;
      ctrl_wr(32'h141);
      for (int i = 0; i < 16; i++) conv(12'(12'h100 + i), ch_at(0, i), 1'b0, 32'h0);
      tick();
      check("t3_starts", starts - s0, 32'd16);
      rd(1'b0, v); check("t3_full_status", v, 32'h0010_0001);

      // T3b: pop during the 16th push
      ctrl_wr(32'h101);
      for (int i = 0; i < 16; i++) conv(12'(12'h200 + i), ch_at(0, i), i == 15, word(12'h200, ch_at(0, 0)));
      tick();
      rd(1'b0, v); check("t3_pushpop_status", v, 32'h000F_0001);

      // T4: same-cycle read+write returns pre-write status, then abort at conversion 4
      read = 1'b1; write = 1'b1; addr = 1'b0; writedatain = 32'h81;
      tick();
      read = 1'b0; write = 1'b0;
      check("t4_rw_status", readdataout, 32'h000F_0001);
      s0 = starts;
      for (int i = 0; i < 3; i++) conv(12'(12'h300 + i), ch_at(0, i), 1'b0, 32'h0);
      wait_start(ch_at(0, 3));
      tick();
      ctrl_wr(32'h0);
      rd(1'b0, v); check("t4_abort_status", v, 32'h0);
      check("t4_starts", starts - s0, 32'd4);
      conv_done = 1'b1; conv_data = 12'hABC;
      tick();
      conv_done = 1'b0;
      repeat (10) tick();
      check("t4_late_starts", starts - s0, 32'd4);
      rd(1'b0, v); check("t4_late_status", v, 32'h0);

      // T5: reset during WAIT
      s0 = starts;
      ctrl_wr(32'h2B);
      wait_start(3'd5);
      rd(1'b0, v); check("t5_busy", v, 32'h0000_0002);
      reset_in = 1'b1;
      tick();
      check("t5_rst_start", {31'b0, conv_start}, 32'h0);
      check("t5_rst_ch", {29'b0, conv_ch}, 32'h0);
      check("t5_rst_rdata", readdataout, 32'h0);
      reset_in = 1'b0;
      conv_done = 1'b1; conv_data = 12'h555;
      tick();
      conv_done = 1'b0;
      repeat (5) tick();
      rd(1'b0, v); check("t5_status", v, 32'h0);
      check("t5_starts", starts - s0, 32'd1);

      // T6: ch 6, count 4 -- scan tags or fixed channel
      ctrl_wr(32'h4D);
      for (int i = 0; i < 4; i++) conv(12'(12'h600 + i), ch_at(6, i), 1'b0, 32'h0);
      tick();
      rd(1'b0, v); check("t6_status", v, 32'h0004_0001);
      for (int i = 0; i < 4; i++) begin
         rd(1'b1, v);
         check("t6_data", v, word(12'(12'h600 + i), ch_at(6, i)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
